// File: rtl/mul_div_unit_if.sv
// Request/response bundle between a requester and the iterative multiply/divide unit.
// Latency: none (wires only).
// Backpressure: none; the requester watches busy, and start is ignored while busy is high.
interface mul_div_unit_if #(
    parameter int DATA_BITS = 32
);
    logic                   start;
    logic [1:0]             op;
    logic [DATA_BITS-1:0]   a;
    logic [DATA_BITS-1:0]   b;
    logic                   busy;
    logic                   ready;
    logic [2*DATA_BITS-1:0] result;

    modport master (
        output start, op, a, b,
        input  busy, ready, result
    );

    modport slave (
        input  start, op, a, b,
        output busy, ready, result
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative signed/unsigned multiply (shift-add) and restoring divide, one bit per cycle.
// Latency: DATA_BITS+2 edges from the start edge to the rising edge of ready, for every op.
// Backpressure: start is sampled only in IDLE; requests that arrive while busy are dropped.
module mul_div_unit #(
    parameter int DATA_BITS = 32
) (
    input  logic         clk,
    input  logic         rst,
    mul_div_unit_if.slave bus
);
    localparam int N     = DATA_BITS;
    localparam int CNT_W = $clog2(DATA_BITS);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       op_q;
    logic [N-1:0]     m_q;
    logic [N-1:0]     acc_hi;
    logic [N-1:0]     acc_lo;
    logic [N-1:0]     hi_nxt;
    logic [N-1:0]     lo_nxt;
    logic             neg_lo;
    logic             neg_hi;
    logic [CNT_W-1:0] cnt;
    logic             ready_q;
    logic [2*N-1:0]   result_q;
    logic [2*N-1:0]   result_fix;

    logic             in_signed;
    logic             a_neg;
    logic             b_neg;
    logic             b_zero;
    logic [N-1:0]     a_mag;
    logic [N-1:0]     b_mag;
    logic             is_div;
    logic             last_iter;
    logic [N:0]       sum;
    logic [N:0]       shifted;
    logic [N:0]       diff;
    logic [2*N-1:0]   prod;

    assign in_signed = ~bus.op[0];
    assign a_neg     = in_signed & bus.a[N-1];
    assign b_neg     = in_signed & bus.b[N-1];
    assign b_zero    = (bus.b == '0);
    assign a_mag     = a_neg ? -bus.a : bus.a;
    assign b_mag     = b_neg ? -bus.b : bus.b;
    assign is_div    = op_q[1];
    assign last_iter = (cnt == CNT_W'(N - 1));
    assign prod      = {acc_hi, acc_lo};

    // Multiply keeps {partial, multiplier} in acc; divide keeps {remainder, dividend/quotient}.
    always_comb begin
        sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, m_q} : '0);
        shifted = {acc_hi, acc_lo[N-1]};
        diff    = shifted - {1'b0, m_q};
        if (is_div) begin
            hi_nxt = diff[N] ? shifted[N-1:0] : diff[N-1:0];
            lo_nxt = {acc_lo[N-2:0], ~diff[N]};
        end else begin
            hi_nxt = sum[N:1];
            lo_nxt = {sum[0], acc_lo[N-1:1]};
        end
    end

    always_comb begin
        result_fix = neg_lo ? -prod : prod;
        if (is_div) begin
            result_fix = {(neg_hi ? -acc_hi : acc_hi), (neg_lo ? -acc_lo : acc_lo)};
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.start) state_nxt = CALC;
            CALC: if (last_iter) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: if (ready_q) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // A zero divisor leaves the quotient unsigned all-ones; the remainder sign fix restores raw a.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q     <= '0;
            m_q      <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
            cnt      <= '0;
            ready_q  <= 1'b0;
            result_q <= '0;
        end else begin
            ready_q <= (state == DONE) && !ready_q;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_q   <= bus.op;
                        m_q    <= bus.op[1] ? b_mag : a_mag;
                        acc_hi <= '0;
                        acc_lo <= bus.op[1] ? a_mag : b_mag;
                        neg_lo <= (a_neg ^ b_neg) & ~(bus.op[1] & b_zero);
                        neg_hi <= a_neg;
                        cnt    <= '0;
                    end
                end
                CALC: begin
                    acc_hi <= hi_nxt;
                    acc_lo <= lo_nxt;
                    cnt    <= cnt + CNT_W'(1);
                end
                FIX: result_q <= result_fix;
                default: ;
            endcase
        end
    end

    assign bus.busy   = (state != IDLE);
    assign bus.ready  = ready_q;
    assign bus.result = result_q;
endmodule
